// File: rtl/sdram_s1_arbiter.sv
// Two-master arbiter for the sdram_s1 Avalon slave. An in-order read-ID FIFO
// steers each s_readdatavalid back to the master that issued the read.
module sdram_s1_arbiter #(
  parameter int MAX_PEND = 4,
  parameter int ADDR_W   = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [1:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [15:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [15:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [1:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [15:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [15:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [1:0]        s_byteenable_n,
  output logic              s_chipselect,
  output logic              s_read_n,
  output logic              s_write_n,
  output logic [15:0]       s_writedata,
  input  logic [15:0]       s_readdata,
  input  logic              s_readdatavalid,
  input  logic              s_waitrequest,
  output logic              err_orphan
);
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [MAX_PEND-1:0] ids_q, ids_d;
  logic              err_orphan_q, err_orphan_d;

  logic fifo_full, fifo_empty, elig0, elig1, pop, push, head_id, g_read, g_write;

  always_comb begin
    fifo_full  = (count_q == CNT_W'(MAX_PEND));
    fifo_empty = (count_q == '0);
    elig0      = (m0_read | m0_write) & (m0_write | ~fifo_full);
    elig1      = (m1_read | m1_write) & (m1_write | ~fifo_full);
    pop        = s_readdatavalid & ~fifo_empty;
    head_id    = ids_q[rd_ptr_q];
  end

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~head_id;
  assign m1_readdatavalid = pop & head_id;
  assign err_orphan       = err_orphan_q;

  // Slave port mux: a granted master sees the slave directly; both-high is a write.
  always_comb begin
    g_read         = 1'b0;
    g_write        = 1'b0;
    s_chipselect   = 1'b0;
    s_read_n       = 1'b1;
    s_write_n      = 1'b1;
    s_address      = '0;
    s_byteenable_n = 2'b11;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GNT0: begin
        g_write        = m0_write;
        g_read         = m0_read & ~m0_write;
        s_chipselect   = 1'b1;
        s_read_n       = ~g_read;
        s_write_n      = ~g_write;
        s_address      = m0_address;
        s_byteenable_n = ~m0_byteenable;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        g_write        = m1_write;
        g_read         = m1_read & ~m1_write;
        s_chipselect   = 1'b1;
        s_read_n       = ~g_read;
        s_write_n      = ~g_write;
        s_address      = m1_address;
        s_byteenable_n = ~m1_byteenable;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the master that did not win last time goes first.
        if (elig0 && (!elig1 || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (elig1) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!(g_read | g_write)) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
          push    = g_read;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ids_d        = ids_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q;
    if (push) begin
      ids_d[wr_ptr_q] = (state_q == GNT1);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (s_readdatavalid && fifo_empty) err_orphan_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ids_q        <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ids_q        <= ids_d;
      err_orphan_q <= err_orphan_d;
    end
  end
endmodule

// File: tb/tb_sdram_s1_arbiter.sv
// Self-checking bench for sdram_s1_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
module tb_sdram_s1_arbiter;
  localparam int MAX_PEND = 4;
  localparam int ADDR_W   = 25;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable_n;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        s_chipselect, s_read_n, s_write_n;
  logic [15:0] s_writedata, s_readdata;
  logic        s_readdatavalid, s_waitrequest, err_orphan;

  int checks = 0;
  int errors = 0;

  // Model: granted master (-1 = none), last winner, outstanding read owners.
  int mdl_gnt;
  int mdl_last;
  int mdl_q[$];
  bit mdl_orphan;

  always #5 clk = ~clk;

  sdram_s1_arbiter #(.MAX_PEND(MAX_PEND), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_byteenable_n(s_byteenable_n), .s_chipselect(s_chipselect),
    .s_read_n(s_read_n), .s_write_n(s_write_n), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_waitrequest(s_waitrequest), .err_orphan(err_orphan)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check every output against the model, then advance the model.
  task automatic applyStimulus(output bit acc0, output bit acc1);
    logic e_w0, e_w1, e_cs, e_rdn, e_wrn, e_rdv0, e_rdv1;
    logic [ADDR_W-1:0] e_addr;
    logic [1:0]  e_ben;
    logic [15:0] e_wd;
    logic req0, req1, el0, el1, g_req, g_rd, do_push;
    int nxt;
    #1;
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    e_w0 = 1'b1; e_w1 = 1'b1; e_cs = 1'b0; e_rdn = 1'b1; e_wrn = 1'b1;
    e_addr = '0; e_ben = 2'b11; e_wd = '0;
    if (mdl_gnt == 0) begin
      e_w0 = s_waitrequest; e_cs = 1'b1; e_rdn = !(m0_read && !m0_write); e_wrn = !m0_write;
      e_addr = m0_address; e_ben = ~m0_byteenable; e_wd = m0_writedata;
    end else if (mdl_gnt == 1) begin
      e_w1 = s_waitrequest; e_cs = 1'b1; e_rdn = !(m1_read && !m1_write); e_wrn = !m1_write;
      e_addr = m1_address; e_ben = ~m1_byteenable; e_wd = m1_writedata;
    end
    e_rdv0 = 1'b0; e_rdv1 = 1'b0;
    if (s_readdatavalid && mdl_q.size() > 0) begin
      e_rdv0 = (mdl_q[0] == 0);
      e_rdv1 = (mdl_q[0] == 1);
    end
    checkOutput("waitrequest", 64'({m0_waitrequest, m1_waitrequest}), 64'({e_w0, e_w1}));
    checkOutput("slave_ctrl", 64'({s_chipselect, s_read_n, s_write_n, s_byteenable_n}),
                64'({e_cs, e_rdn, e_wrn, e_ben}));
    checkOutput("slave_addr", 64'(s_address), 64'(e_addr));
    checkOutput("slave_wdata", 64'(s_writedata), 64'(e_wd));
    checkOutput("readdatavalid", 64'({m0_readdatavalid, m1_readdatavalid}), 64'({e_rdv0, e_rdv1}));
    checkOutput("readdata", 64'({m0_readdata, m1_readdata}), 64'({s_readdata, s_readdata}));
    checkOutput("err_orphan", 64'(err_orphan), 64'(mdl_orphan));
    acc0 = req0 && !m0_waitrequest;
    acc1 = req1 && !m1_waitrequest;
    @(posedge clk);
    if (reset) begin
      mdl_gnt = -1; mdl_last = 1; mdl_q.delete(); mdl_orphan = 1'b0;
    end else begin
      nxt = mdl_gnt;
      do_push = 1'b0;
      el0 = req0 && (m0_write || mdl_q.size() < MAX_PEND);
      el1 = req1 && (m1_write || mdl_q.size() < MAX_PEND);
      if (mdl_gnt == -1) begin
        if (el0 && el1) nxt = (mdl_last == 0) ? 1 : 0;
        else if (el0) nxt = 0;
        else if (el1) nxt = 1;
        if (nxt != -1) mdl_last = nxt;
      end else begin
        g_req = (mdl_gnt == 0) ? req0 : req1;
        g_rd  = (mdl_gnt == 0) ? (m0_read && !m0_write) : (m1_read && !m1_write);
        if (!g_req) nxt = -1;
        else if (!s_waitrequest) begin
          nxt = -1;
          do_push = g_rd;
        end
      end
      if (s_readdatavalid) begin
        if (mdl_q.size() > 0) void'(mdl_q.pop_front());
        else mdl_orphan = 1'b1;
      end
      if (do_push) mdl_q.push_back(mdl_gnt);
      mdl_gnt = nxt;
    end
    @(negedge clk);
  endtask

  initial begin
    bit a0, a1, wrote;
    int order[$];
    int n_acc;
    int drain_exp[3];
    reset = 1'b1;
    m0_address = '0; m0_byteenable = '0; m0_read = 0; m0_write = 0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    s_readdata = 16'hA5A5; s_readdatavalid = 0; s_waitrequest = 0;
    @(posedge clk);
    @(negedge clk);
    mdl_gnt = -1; mdl_last = 1; mdl_q.delete(); mdl_orphan = 1'b0;
    applyStimulus(a0, a1);
    reset = 1'b0;
    applyStimulus(a0, a1);

    // Single write from m0 reaches the slave one cycle after it is seen.
    m0_address = 25'h0000123; m0_writedata = 16'hBEEF; m0_byteenable = 2'b01; m0_write = 1;
    #1 checkOutput("wr_idle_stall", 64'(m0_waitrequest), 64'(1));
    applyStimulus(a0, a1);
    #1;
    checkOutput("wr_write_n", 64'(s_write_n), 64'(0));
    checkOutput("wr_be_n", 64'(s_byteenable_n), 64'(2'b10));
    checkOutput("wr_addr", 64'(s_address), 64'(25'h0000123));
    checkOutput("wr_m0_wait", 64'(m0_waitrequest), 64'(0));
    applyStimulus(a0, a1);
    checkOutput("wr_accept", 64'(a0), 64'(1));
    m0_write = 0;
    #1;
    checkOutput("wr_back_idle_cs", 64'(s_chipselect), 64'(0));
    checkOutput("wr_back_idle_wait", 64'(m0_waitrequest), 64'(1));

    // Contention: continuous reads from both masters alternate from reset.
    reset = 1'b1; applyStimulus(a0, a1); reset = 1'b0;
    m0_read = 1; m0_address = 25'h10; m1_read = 1; m1_address = 25'h20;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(a0, a1);
      if (a0) order.push_back(0);
      if (a1) order.push_back(1);
      if (order.size() == 4) break;
    end
    checkOutput("contention_grants", 64'(order.size()), 64'(4));
    for (int i = 0; i < order.size() && i < 4; i++)
      checkOutput("contention_order", 64'(order[i]), 64'(i % 2));

    // FIFO full: m1 read stalls while an m0 write is still granted.
    m0_read = 0; m0_write = 1; m0_address = 25'h30; m0_writedata = 16'h1234;
    wrote = 0;
    for (int i = 0; i < 4; i++) begin
      #1 checkOutput("full_m1_stall", 64'(m1_waitrequest), 64'(1));
      applyStimulus(a0, a1);
      if (a0) begin wrote = 1; m0_write = 0; end
    end
    checkOutput("full_write_granted", 64'(wrote), 64'(1));

    // Full release: a pop frees a slot, then push and pop land together.
    s_readdatavalid = 1;
    #1 checkOutput("pop_head0", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(2'b10));
    applyStimulus(a0, a1);
    s_readdatavalid = 0;
    applyStimulus(a0, a1);
    s_readdatavalid = 1;
    #1;
    checkOutput("release_grant", 64'(m1_waitrequest), 64'(0));
    checkOutput("release_pop_head1", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(2'b01));
    applyStimulus(a0, a1);
    checkOutput("release_accept", 64'(a1), 64'(1));
    m1_read = 0;
    drain_exp = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("drain_route", 64'({m0_readdatavalid, m1_readdatavalid}),
                     64'((drain_exp[i] == 0) ? 2'b10 : 2'b01));
      applyStimulus(a0, a1);
    end
    s_readdatavalid = 0;

    // Slave stall holds the command steady; then an orphan response.
    m0_read = 1; m0_address = 25'h55; s_waitrequest = 1;
    applyStimulus(a0, a1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall_read_n", 64'(s_read_n), 64'(0));
      checkOutput("stall_addr", 64'(s_address), 64'(25'h55));
      checkOutput("stall_m0_wait", 64'(m0_waitrequest), 64'(1));
      applyStimulus(a0, a1);
    end
    s_waitrequest = 0;
    applyStimulus(a0, a1);
    checkOutput("stall_accept", 64'(a0), 64'(1));
    m0_read = 0;
    s_readdatavalid = 1;
    #1 checkOutput("stall_resp", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(2'b10));
    applyStimulus(a0, a1);
    #1 checkOutput("orphan_dropped", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    applyStimulus(a0, a1);
    s_readdatavalid = 0;
    #1 checkOutput("orphan_set", 64'(err_orphan), 64'(1));

    // Reset during GNT1 with two reads outstanding.
    reset = 1'b1; applyStimulus(a0, a1); reset = 1'b0;
    #1 checkOutput("reset_clears_orphan", 64'(err_orphan), 64'(0));
    m0_read = 1; m1_read = 1; n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 2; i++) begin
      applyStimulus(a0, a1);
      if (a0) begin m0_read = 0; n_acc++; end
      if (a1) begin m1_read = 0; n_acc++; end
    end
    checkOutput("midreset_two_reads", 64'(n_acc), 64'(2));
    m1_read = 1; s_waitrequest = 1;
    applyStimulus(a0, a1);
    #1 checkOutput("midreset_in_gnt1", 64'(s_chipselect), 64'(1));
    reset = 1'b1; applyStimulus(a0, a1); reset = 1'b0;
    m1_read = 0; s_waitrequest = 0;
    #1;
    checkOutput("midreset_idle_cs", 64'(s_chipselect), 64'(0));
    checkOutput("midreset_idle_wait", 64'(m1_waitrequest), 64'(1));
    s_readdatavalid = 1;
    #1 checkOutput("midreset_no_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    applyStimulus(a0, a1);
    s_readdatavalid = 0;
    #1 checkOutput("midreset_orphan", 64'(err_orphan), 64'(1));

    // Random traffic against the model.
    reset = 1'b1; applyStimulus(a0, a1); reset = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(m0_read | m0_write) && $urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0: begin m0_read = 1; m0_write = 0; end
          1: begin m0_read = 0; m0_write = 1; end
          default: begin m0_read = 1; m0_write = 1; end
        endcase
        m0_address = ADDR_W'($urandom); m0_byteenable = 2'($urandom); m0_writedata = 16'($urandom);
      end
      if (!(m1_read | m1_write) && $urandom_range(3) == 0) begin
        case ($urandom_range(2))
          0: begin m1_read = 1; m1_write = 0; end
          1: begin m1_read = 0; m1_write = 1; end
          default: begin m1_read = 1; m1_write = 1; end
        endcase
        m1_address = ADDR_W'($urandom); m1_byteenable = 2'($urandom); m1_writedata = 16'($urandom);
      end
      s_waitrequest   = ($urandom_range(9) < 3);
      s_readdatavalid = (mdl_q.size() > 0) ? ($urandom_range(3) == 0) : ($urandom_range(49) == 0);
      s_readdata      = 16'($urandom);
      reset           = ($urandom_range(499) == 0);
      applyStimulus(a0, a1);
      if (a0 || $urandom_range(99) == 0) begin m0_read = 0; m0_write = 0; end
      if (a1 || $urandom_range(99) == 0) begin m1_read = 0; m1_write = 0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
